instruction_memory: RTL and testbench



---
 rtl/instruction_memory_pkg.sv | 37 +++
 rtl/instruction_memory_addr_check.sv | 27 ++
 rtl/instruction_memory.sv | 134 +++++++++++++
 tb/tb_instruction_memory.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/instruction_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_memory_pkg
//  Description : Shared constants for the instruction memory: word width,
//                the NOP word, the default program image and a lookup
//                function that returns the image entry for a word index.
//  Revision    : 1.0 - initial release
// ============================================================================
package instruction_memory_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

    // Default program image, loaded at words 0..4. Every other word is NOP.
    localparam logic [WORD_W-1:0] IMEM_INIT_0 = 32'h2001_0005;
    localparam logic [WORD_W-1:0] IMEM_INIT_1 = 32'h2002_000A;
    localparam logic [WORD_W-1:0] IMEM_INIT_2 = 32'h0022_1820;
    localparam logic [WORD_W-1:0] IMEM_INIT_3 = 32'hAC03_0000;
    localparam logic [WORD_W-1:0] IMEM_INIT_4 = 32'h0800_0000;

    // Returns the default-image contents of word idx (NOP outside the image).
    function automatic logic [WORD_W-1:0] default_word(input int idx);
        logic [WORD_W-1:0] word;
        case (idx)
            0:       word = IMEM_INIT_0;
            1:       word = IMEM_INIT_1;
            2:       word = IMEM_INIT_2;
            3:       word = IMEM_INIT_3;
            4:       word = IMEM_INIT_4;
            default: word = NOP_WORD;
        endcase
        return word;
    endfunction

endpackage : instruction_memory_pkg
`default_nettype wire

// File: rtl/instruction_memory_addr_check.sv
`default_nettype none
// ============================================================================
//  Module      : imem_addr_check
//  Description : Combinational range check for a 32-bit word address against
//                DEPTH. Produces an in-range flag and the truncated array
//                index. Shared by the read path and the program-load path.
//  Ports       : addr      - 32-bit word address to check
//                in_range  - 1 when addr < DEPTH
//                idx       - addr truncated to the array index width
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_addr_check #(
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic [31:0]       addr,
    output logic              in_range,
    output logic [ADDR_W-1:0] idx
);

    // DEPTH is a power of two, so an address is in range exactly when no bit
    // above the index field is set. No wrap-around into the array.
    assign in_range = (addr[31:ADDR_W] == '0);
    assign idx      = addr[ADDR_W-1:0];

endmodule : imem_addr_check
`default_nettype wire

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_memory
//  Description : Word-addressed instruction store with a one-cycle registered
//                read. Holds a fixed default program image; out-of-range
//                addresses read as NOP and raise addr_err.
//                Optional run-time program load is enabled by defining the
//                macro IMEM_PROG_LOAD_EN.
//  Ports       : clk        - system clock, rising edge
//                rst_n      - asynchronous active-low reset
//                add_in     - 32-bit word index to read
//                i_out      - registered instruction word
//                addr_err   - registered flag, last sampled add_in >= DEPTH
//                prog_we    - (IMEM_PROG_LOAD_EN) write enable
//                prog_addr  - (IMEM_PROG_LOAD_EN) 32-bit word index to write
//                prog_data  - (IMEM_PROG_LOAD_EN) word to write
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory
    import instruction_memory_pkg::*;
#(
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       add_in,
`ifdef IMEM_PROG_LOAD_EN
    input  logic              prog_we,
    input  logic [31:0]       prog_addr,
    input  logic [WORD_W-1:0] prog_data,
`endif
    output logic [WORD_W-1:0] i_out,
    output logic              addr_err
);

    // ------------------------------------------------------------------
    // Read address check
    // ------------------------------------------------------------------
    logic              rd_in_range;
    logic [ADDR_W-1:0] rd_idx;

    imem_addr_check #(
        .DEPTH    (DEPTH)
    ) u_rd_check (
        .addr     (add_in),
        .in_range (rd_in_range),
        .idx      (rd_idx)
    );

    // Current array contents as seen by the read path.
    logic [WORD_W-1:0] mem_word [DEPTH];

`ifdef IMEM_PROG_LOAD_EN
    // ------------------------------------------------------------------
    // Writable array: reset reloads the default image, writes land at the
    // edge, so a same-edge read of the written word still returns the old
    // contents.
    // ------------------------------------------------------------------
    logic              wr_in_range;
    logic [ADDR_W-1:0] wr_idx;

    imem_addr_check #(
        .DEPTH    (DEPTH)
    ) u_wr_check (
        .addr     (prog_addr),
        .in_range (wr_in_range),
        .idx      (wr_idx)
    );

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (prog_we && wr_in_range) begin
            mem_d[wr_idx] = prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= default_word(i);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        mem_word = mem_q;
    end
`else
    // ------------------------------------------------------------------
    // Read-only array: contents are the constant default image.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign mem_word[gi] = default_word(gi);
    end
`endif

    // ------------------------------------------------------------------
    // Registered read
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] i_out_d;
    logic [WORD_W-1:0] i_out_q;
    logic              addr_err_d;
    logic              addr_err_q;

    always_comb begin
        i_out_d    = NOP_WORD;
        addr_err_d = 1'b1;
        if (rd_in_range) begin
            i_out_d    = mem_word[rd_idx];
            addr_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_out_q    <= NOP_WORD;
            addr_err_q <= 1'b0;
        end else begin
            i_out_q    <= i_out_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign i_out    = i_out_q;
    assign addr_err = addr_err_q;

endmodule : instruction_memory
`default_nettype wire

// File: tb/tb_instruction_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_memory
//  Description : Directed self-checking bench for instruction_memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_memory;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic [31:0] add_in;
    logic [31:0] i_out;
    logic        addr_err;
`ifdef IMEM_PROG_LOAD_EN
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
`endif

    int vectors;
    int miscompares;

    instruction_memory #(
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .add_in    (add_in),
`ifdef IMEM_PROG_LOAD_EN
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
`endif
        .i_out     (i_out),
        .addr_err  (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp_word,
                         input logic exp_err);
        vectors++;
        assert (i_out === exp_word) else begin
            miscompares++;
            $error("FAIL %s i_out observed=%h expected=%h", tag, i_out, exp_word);
        end
        vectors++;
        assert (addr_err === exp_err) else begin
            miscompares++;
            $error("FAIL %s addr_err observed=%b expected=%b", tag, addr_err, exp_err);
        end
    endtask

    // Present an address on the falling edge, then sample just after the
    // following rising edge.
    task automatic read(input logic [31:0] addr, input string tag,
                        input logic [31:0] exp_word, input logic exp_err);
        @(negedge clk);
        add_in = addr;
        @(posedge clk);
        #1;
        check(tag, exp_word, exp_err);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        add_in      = 32'd0;
`ifdef IMEM_PROG_LOAD_EN
        prog_we     = 1'b0;
        prog_addr   = 32'd0;
        prog_data   = 32'd0;
`endif

        // Reset held across a few edges
        repeat (3) @(posedge clk);
        #1;
        check("reset", 32'h0000_0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential read of the default image
        read(32'd0, "seq0", 32'h2001_0005, 1'b0);
        read(32'd1, "seq1", 32'h2002_000A, 1'b0);
        read(32'd2, "seq2", 32'h0022_1820, 1'b0);
        read(32'd3, "seq3", 32'hAC03_0000, 1'b0);
        read(32'd4, "seq4", 32'h0800_0000, 1'b0);

        // Latency and hold: mid-cycle address change has no effect until edge
        read(32'd0, "hold_a", 32'h2001_0005, 1'b0);
        @(negedge clk);
        add_in = 32'd3;
        #1;
        check("hold_mid", 32'h2001_0005, 1'b0);
        @(posedge clk);
        #1;
        check("hold_b", 32'hAC03_0000, 1'b0);

        // Boundaries
        read(32'd63,         "last_valid", 32'h0000_0000, 1'b0);
        read(32'd64,         "depth",      32'h0000_0000, 1'b1);
        read(32'hFFFF_FFFF,  "all_ones",   32'h0000_0000, 1'b1);
        read(32'h0000_0041,  "depth_p1",   32'h0000_0000, 1'b1);
        read(32'd1,          "recover",    32'h2002_000A, 1'b0);

        // Async reset mid-stream while reading word 2
        read(32'd2, "pre_rst", 32'h0022_1820, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'h0000_0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst", 32'h0022_1820, 1'b0);

        // Async reset also clears a pending error flag
        read(32'd64, "pre_rst_err", 32'h0000_0000, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_err", 32'h0000_0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        read(32'd4, "post_rst_err", 32'h0800_0000, 1'b0);

`ifdef IMEM_PROG_LOAD_EN
        // Write word 5 while reading it: old value this edge, new value next
        @(negedge clk);
        add_in    = 32'd5;
        prog_we   = 1'b1;
        prog_addr = 32'd5;
        prog_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check("wr_same_edge", 32'h0000_0000, 1'b0);
        @(negedge clk);
        prog_we = 1'b0;
        @(posedge clk);
        #1;
        check("wr_visible", 32'hDEAD_BEEF, 1'b0);

        // Reset restores the default image
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        read(32'd5, "wr_reset", 32'h0000_0000, 1'b0);

        // Out-of-range write is ignored
        @(negedge clk);
        add_in    = 32'd100;
        prog_we   = 1'b1;
        prog_addr = 32'd100;
        prog_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("wr_oob_read", 32'h0000_0000, 1'b1);
        @(negedge clk);
        prog_we = 1'b0;
        read(32'd36, "wr_oob_alias", 32'h0000_0000, 1'b0);
        read(32'd0,  "wr_oob_w0",    32'h2001_0005, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_instruction_memory
`default_nettype wire
